// File: rtl/mc_issue_scheduler.sv
// Multicycle issue scheduler: launches one operand every R cycles and captures the result at phase R-1.
// Optional launch/stall statistics are compiled in when MC_SCHED_STATS_EN is defined.
module mc_issue_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic             pll_clock,
    input  logic             reset_n,
    input  logic [3:0]       cfg_ratio,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             launch_en,
    output logic [WIDTH-1:0] launch_data,
    output logic             capture_en,
    input  logic [WIDTH-1:0] res_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef MC_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_launch,
    output logic [15:0]      stat_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       phase_q, phase_d;
    logic [3:0]       ratio_q, ratio_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] launch_data_q, launch_data_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic active_s;
    logic last_phase_s;
    logic stall_s;
    logic capture_s;
    logic launch_s;
    logic accept_start_s;

    // Window status: a capture is due at the last phase unless the output slot is still occupied
    always_comb begin
        active_s       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        last_phase_s   = (phase_q == (ratio_q - 4'd1));
        stall_s        = active_s && last_phase_s && inflight_q && out_valid_q && !out_ready;
        capture_s      = active_s && last_phase_s && inflight_q && !stall_s;
        launch_s       = (state_q == ST_RUN) && (phase_q == 4'd0) && in_valid;
        accept_start_s = (state_q == ST_IDLE) && start;
    end

    // FSM state register
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DRAIN leaves as soon as nothing is left in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (stop) state_d = ST_DRAIN;
                else      state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!inflight_q || capture_s) state_d = ST_IDLE;
                else                          state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and strobes are combinational on the current phase
    always_comb begin
        busy       = (state_q != ST_IDLE);
        in_ready   = (state_q == ST_RUN) && (phase_q == 4'd0);
        launch_en  = launch_s;
        capture_en = capture_s;
    end

    // Datapath next-state: ratio latch, phase counter, in-flight tracking, operand/result registers
    always_comb begin
        if (accept_start_s) begin
            ratio_d = (cfg_ratio < 4'd2) ? 4'd2 : cfg_ratio;
        end else begin
            ratio_d = ratio_q;
        end

        if (!active_s || (state_d == ST_IDLE)) begin
            phase_d = 4'd0;
        end else if (stall_s) begin
            phase_d = phase_q;
        end else if (last_phase_s) begin
            phase_d = 4'd0;
        end else begin
            phase_d = phase_q + 4'd1;
        end

        if (launch_s) begin
            inflight_d = 1'b1;
        end else if (capture_s || !active_s) begin
            inflight_d = 1'b0;
        end else begin
            inflight_d = inflight_q;
        end

        if (launch_s) begin
            launch_data_d = in_data;
        end else begin
            launch_data_d = launch_data_q;
        end

        if (capture_s) begin
            out_valid_d = 1'b1;
            out_data_d  = res_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
    end

    // Datapath registers
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q       <= 4'd0;
            ratio_q       <= 4'd2;
            inflight_q    <= 1'b0;
            launch_data_q <= {WIDTH{1'b0}};
            out_data_q    <= {WIDTH{1'b0}};
            out_valid_q   <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            ratio_q       <= ratio_d;
            inflight_q    <= inflight_d;
            launch_data_q <= launch_data_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign launch_data = launch_data_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

`ifdef MC_SCHED_STATS_EN
    logic [15:0] stat_launch_q, stat_launch_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    // Saturating statistics, restarted with every accepted start
    always_comb begin
        if (accept_start_s) begin
            stat_launch_d = 16'd0;
        end else if (launch_s && (stat_launch_q != 16'hFFFF)) begin
            stat_launch_d = stat_launch_q + 16'd1;
        end else begin
            stat_launch_d = stat_launch_q;
        end

        if (accept_start_s) begin
            stat_stall_d = 16'd0;
        end else if (stall_s && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Statistics registers
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_launch_q <= 16'd0;
            stat_stall_q  <= 16'd0;
        end else begin
            stat_launch_q <= stat_launch_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_launch = stat_launch_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_mc_issue_scheduler.sv
// Self-checking bench for mc_issue_scheduler: directed timing scenarios plus a randomized run
// against a rule-level reference model. Stats checks are active when MC_SCHED_STATS_EN is defined.
module tb_mc_issue_scheduler;
    localparam int W = 32;

    logic         pll_clock = 1'b0;
    logic         reset_n   = 1'b0;
    logic [3:0]   cfg_ratio = 4'd0;
    logic         start     = 1'b0;
    logic         stop      = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic [W-1:0] res_data  = '0;
    logic         out_ready = 1'b0;
    logic         busy, in_ready, launch_en, capture_en, out_valid;
    logic [W-1:0] launch_data, out_data;
`ifdef MC_SCHED_STATS_EN
    logic [15:0]  stat_launch, stat_stall;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (spec-level view of the scheduler)
    int           m_st;
    int           m_ph;
    int           m_r;
    logic         m_pend;
    logic         m_ov;
    logic [W-1:0] m_od;
    logic [W-1:0] m_ld;

    mc_issue_scheduler #(.WIDTH(W)) dut (
        .pll_clock   (pll_clock),
        .reset_n     (reset_n),
        .cfg_ratio   (cfg_ratio),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .launch_en   (launch_en),
        .launch_data (launch_data),
        .capture_en  (capture_en),
        .res_data    (res_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
`ifdef MC_SCHED_STATS_EN
        ,
        .stat_launch (stat_launch),
        .stat_stall  (stat_stall)
`endif
    );

    // 100 MHz clock
    always #5 pll_clock = ~pll_clock;

    task automatic next_cycle();
        @(posedge pll_clock);
        #1;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; res_data = '0; cfg_ratio = 4'd0;
        repeat (2) @(posedge pll_clock);
        #1 reset_n = 1'b1;
        m_st = 0; m_ph = 0; m_r = 2; m_pend = 1'b0; m_ov = 1'b0; m_od = '0; m_ld = '0;
    endtask

    // Pulse start with ratio r; returns at cycle 0 of RUN with cfg_ratio scrambled
    task automatic begin_run(input logic [3:0] r);
        cfg_ratio = r;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        cfg_ratio = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({busy, in_ready, launch_en, capture_en, out_valid} !== 5'b0 || launch_data !== '0 || out_data !== '0)
            $display("FAIL reset_hold ctl=%b ld=%h od=%h required all zero",
                     {busy, in_ready, launch_en, capture_en, out_valid}, launch_data, out_data);
        else n_pass++;
        reset_dut();
        #2;
        n_checks++;
        if ({busy, in_ready, launch_en, capture_en, out_valid} !== 5'b0 || launch_data !== '0 || out_data !== '0)
            $display("FAIL reset_release ctl=%b ld=%h od=%h required all zero",
                     {busy, in_ready, launch_en, capture_en, out_valid}, launch_data, out_data);
        else n_pass++;
    endtask

    task automatic test_basic_flow();
        logic [3:0]   exp;
        logic [W-1:0] held, cap;
        held = '0; cap = '0;
        reset_dut();
        out_ready = 1'b1; in_valid = 1'b1;
        begin_run(4'd4);
        for (int c = 0; c < 13; c++) begin
            in_data = $urandom; res_data = $urandom;
            #2;
            exp = {(c % 4 == 0), (c % 4 == 0), (c % 4 == 3), (c >= 4) && (c % 4 == 0)};
            n_checks++;
            if ({launch_en, in_ready, capture_en, out_valid} !== exp)
                $display("FAIL basic_ctl c=%0d got=%b required=%b", c, {launch_en, in_ready, capture_en, out_valid}, exp);
            else n_pass++;
            if (exp[0]) begin
                n_checks++;
                if (out_data !== cap) $display("FAIL basic_out c=%0d got=%h required=%h", c, out_data, cap);
                else n_pass++;
            end
            if (c % 4 == 1) begin
                n_checks++;
                if (launch_data !== held) $display("FAIL basic_launch_data c=%0d got=%h required=%h", c, launch_data, held);
                else n_pass++;
            end
            if (exp[1]) cap = res_data;
            if (exp[3]) held = in_data;
            next_cycle();
        end
    endtask

    task automatic test_clamp();
        logic [2:0]   exp;
        logic [W-1:0] cap;
        cap = '0;
        reset_dut();
        out_ready = 1'b1; in_valid = 1'b1;
        begin_run(4'd0);
        for (int c = 0; c < 8; c++) begin
            in_data = $urandom; res_data = $urandom;
            #2;
            exp = {(c % 2 == 0), (c % 2 == 1), (c >= 2) && (c % 2 == 0)};
            n_checks++;
            if ({launch_en, capture_en, out_valid} !== exp)
                $display("FAIL clamp_ctl c=%0d got=%b required=%b", c, {launch_en, capture_en, out_valid}, exp);
            else n_pass++;
            if (exp[0]) begin
                n_checks++;
                if (out_data !== cap) $display("FAIL clamp_out c=%0d got=%h required=%h", c, out_data, cap);
                else n_pass++;
            end
            if (exp[1]) cap = res_data;
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]   exp;
        logic [W-1:0] cap;
        cap = '0;
        reset_dut();
        in_valid = 1'b1;
        begin_run(4'd3);
        for (int c = 0; c < 10; c++) begin
            out_ready = !((c >= 3) && (c <= 7));
            in_data = $urandom; res_data = $urandom;
            #2;
            exp = {(c == 0) || (c == 3) || (c == 9), (c == 2) || (c == 8), (c >= 3)};
            n_checks++;
            if ({launch_en, capture_en, out_valid} !== exp)
                $display("FAIL backpressure_ctl c=%0d got=%b required=%b", c, {launch_en, capture_en, out_valid}, exp);
            else n_pass++;
            if (exp[0]) begin
                n_checks++;
                if (out_data !== cap) $display("FAIL backpressure_out c=%0d got=%h required=%h", c, out_data, cap);
                else n_pass++;
            end
            if (exp[1]) cap = res_data;
            next_cycle();
        end
    endtask

    task automatic test_stop_drain();
        logic [4:0] exp;
        reset_dut();
        in_valid = 1'b1; out_ready = 1'b1;
        begin_run(4'd5);
        for (int c = 0; c < 7; c++) begin
            stop = (c == 1);
            in_data = $urandom; res_data = $urandom;
            #2;
            exp = {(c <= 4), (c == 0), (c == 0), (c == 4), (c == 5)};
            n_checks++;
            if ({busy, in_ready, launch_en, capture_en, out_valid} !== exp)
                $display("FAIL stop_ctl c=%0d got=%b required=%b", c, {busy, in_ready, launch_en, capture_en, out_valid}, exp);
            else n_pass++;
            next_cycle();
        end
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        reset_dut();
        in_valid = 1'b1; out_ready = 1'b1;
        begin_run(4'd4);
        for (int c = 0; c < 3; c++) begin
            in_data = $urandom | 32'd1;
            if (c < 2) next_cycle();
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_ready, launch_en, capture_en, out_valid} !== 5'b0 || launch_data !== '0 || out_data !== '0)
            $display("FAIL async_reset ctl=%b ld=%h od=%h required all zero",
                     {busy, in_ready, launch_en, capture_en, out_valid}, launch_data, out_data);
        else n_pass++;
        #2 reset_n = 1'b1;
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            #2;
            n_checks++;
            if ({busy, launch_en, capture_en, out_valid} !== 4'b0)
                $display("FAIL post_reset c=%0d got=%b required=0000", c, {busy, launch_en, capture_en, out_valid});
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic exp_busy, exp_ready, exp_launch, at_end, exp_stall, exp_cap;
        int   next_st;
        reset_dut();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = $urandom;
            res_data  = $urandom;
            cfg_ratio = 4'($urandom_range(0, 7));
            start     = (k == 0) || ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            exp_busy   = (m_st != 0);
            exp_ready  = (m_st == 1) && (m_ph == 0);
            exp_launch = exp_ready && in_valid;
            at_end     = exp_busy && (m_ph == m_r - 1);
            exp_stall  = at_end && m_pend && m_ov && !out_ready;
            exp_cap    = at_end && m_pend && !exp_stall;
            #2;
            n_checks++;
            if ({busy, in_ready, launch_en, capture_en, out_valid} !== {exp_busy, exp_ready, exp_launch, exp_cap, m_ov})
                $display("FAIL random_ctl k=%0d got=%b required=%b", k,
                         {busy, in_ready, launch_en, capture_en, out_valid}, {exp_busy, exp_ready, exp_launch, exp_cap, m_ov});
            else n_pass++;
            n_checks++;
            if (launch_data !== m_ld || (m_ov && out_data !== m_od))
                $display("FAIL random_data k=%0d got ld=%h od=%h required ld=%h od=%h", k, launch_data, out_data, m_ld, m_od);
            else n_pass++;
            next_st = m_st;
            if (m_st == 0 && start) next_st = 1;
            else if (m_st == 1 && stop) next_st = 2;
            else if (m_st == 2 && (!m_pend || exp_cap)) next_st = 0;
            if (m_st == 0 && start) m_r = (int'(cfg_ratio) < 2) ? 2 : int'(cfg_ratio);
            if (m_st == 0 || next_st == 0) m_ph = 0;
            else if (!exp_stall) m_ph = (m_ph + 1) % m_r;
            if (exp_launch) begin
                m_pend = 1'b1;
                m_ld   = in_data;
            end else if (exp_cap) begin
                m_pend = 1'b0;
            end
            if (exp_cap) begin
                m_ov = 1'b1;
                m_od = res_data;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            m_st = next_st;
            next_cycle();
        end
        start = 1'b0; stop = 1'b0;
    endtask

`ifdef MC_SCHED_STATS_EN
    task automatic test_stats();
        reset_dut();
        in_valid = 1'b1;
        begin_run(4'd3);
        for (int c = 0; c < 16; c++) begin
            in_valid  = (c <= 11);
            out_ready = !((c >= 3) && (c <= 9));
            stop      = (c == 12);
            next_cycle();
        end
        stop = 1'b0;
        #2;
        n_checks++;
        if (stat_launch !== 16'd3 || stat_stall !== 16'd5)
            $display("FAIL stats got launch=%0d stall=%0d required launch=3 stall=5", stat_launch, stat_stall);
        else n_pass++;
        begin_run(4'd3);
        #2;
        n_checks++;
        if (stat_launch !== 16'd0 || stat_stall !== 16'd0)
            $display("FAIL stats_clear got launch=%0d stall=%0d required 0", stat_launch, stat_stall);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_flow();
        test_clamp();
        test_backpressure();
        test_stop_drain();
        test_async_reset();
        test_random();
`ifdef MC_SCHED_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
